// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with wrap/saturate, load, clear,
// boundary carry pulse and a capture register for a frozen display reading.
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  capture,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   held,
  output logic                  carry,
  output logic                  at_limit
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    held_q;
  logic            carry_q, carry_d;
  logic [W-1:0]    load_clamped;
  logic [W-1:0]    count_step;
  logic [DIGITS:0] en_up, en_dn;

  // Ripple of per-digit terminal detects; en_*[i] means every digit below i is at its terminal value.
  always_comb begin : digit_chain
    en_up        = '0;
    en_dn        = '0;
    load_clamped = '0;
    count_step   = '0;
    en_up[0]     = 1'b1;
    en_dn[0]     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      en_up[i+1] = en_up[i] & (count_q[4*i +: 4] == 4'd9);
      en_dn[i+1] = en_dn[i] & (count_q[4*i +: 4] == 4'd0);
      load_clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
      if (up) begin
        if (en_up[i]) begin
          count_step[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
        end else begin
          count_step[4*i +: 4] = count_q[4*i +: 4];
        end
      end else begin
        if (en_dn[i]) begin
          count_step[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
        end else begin
          count_step[4*i +: 4] = count_q[4*i +: 4];
        end
      end
    end
  end

  assign at_limit = up ? en_up[DIGITS] : en_dn[DIGITS];

  // clear > load > tick; a full-range step wraps naturally through the chain.
  always_comb begin : next_state
    count_d = count_q;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (tick) begin
      carry_d = at_limit;
      if (!(SATURATE && at_limit)) begin
        count_d = count_step;
      end
    end
  end

  always_ff @(posedge clk) begin : regs
    if (!reset_n) begin
      count_q <= '0;
      held_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      if (capture) begin
        held_q <= count_q;
      end
    end
  end

  assign count = count_q;
  assign held  = held_q;
  assign carry = carry_q;

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD counter, the next generation of the reaction-timer's fixed four-digit cascade. It counts up or down on a single-cycle `tick` strobe across `DIGITS` decimal digits. It supports wrap or saturate at the range limits, parallel load, synchronous clear, a boundary pulse, and a capture register that freezes a reading for display while counting continues. It sits between the prescaler that generates `tick` and the seven-segment decoders.

## Interface

- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `SATURATE`, default 0: 0 wraps at the range limits; 1 holds at the range limits.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `tick`  in  1  count strobe; one step per cycle in which it is high.
- `up`  in  1  direction; 1 counts up, 0 counts down; sampled with `tick`.
- `clear`  in  1  synchronous clear of `count` to all zeros.
- `load`  in  1  synchronous parallel load from `load_value`.
- `load_value`  in  4*DIGITS  BCD value to load; digit i occupies bits [4i+3:4i].
- `capture`  in  1  latches the current `count` into `held`.
- `count`  out  4*DIGITS  live BCD count; digit 0 is the least significant digit, in bits [3:0].
- `held`  out  4*DIGITS  last captured value.
- `carry`  out  1  registered one-cycle pulse on a boundary event.
- `at_limit`  out  1  combinational; high when `count` is all 9s and `up`=1, or all 0s and `up`=0.

## Operation

- Reset (`reset_n`=0 at a clock edge) sets `count`=0, `held`=0 and `carry`=0. Reset overrides all other inputs. Reset asserted mid-count discards the count with no carry.
- Priority for `count` when reset is inactive: `clear` > `load` > `tick`. A lower-priority input is ignored in any cycle where a higher-priority input is active, and `carry` stays 0 in that cycle.
- Load: each `load_value` digit greater than 9 is stored as 9. Valid digits are stored unchanged.
- Up step, on `tick` with `up`=1:
  - Digit 0 increments.
  - Digit i steps only when `tick` is high and every lower digit equals 9. A stepping digit goes 9→0, otherwise +1.
- Down step, on `tick` with `up`=0:
  - Digit 0 decrements.
  - Digit i steps only when `tick` is high and every lower digit equals 0. A stepping digit goes 0→9, otherwise −1.
- The enable chain is a ripple of per-digit terminal detects, generated from `DIGITS`. There is no multi-cycle propagation; all digits update on the same edge.
- Boundary event: `tick` is accepted while `at_limit`=1.
  - `SATURATE`=0: `count` wraps to all 0s (up) or all 9s (down), and `carry` pulses.
  - `SATURATE`=1: `count` is unchanged, and `carry` still pulses.
- Capture:
  - `held` loads the pre-edge value of `count` on any edge where `capture`=1 and reset is inactive.
  - `capture` is independent of `clear`, `load` and `tick`. With both `capture` and `tick` high, `held` receives the value before the step.
- `count` and `held` always contain valid BCD digits (0–9).

## Timing

- `count`, `held` and `carry` are registered. Each reflects its inputs one cycle after the sampling edge.
- Latency: `tick` sampled at edge N gives the new `count` visible after edge N. `carry` is high for exactly the cycle following edge N.
- Back-to-back `tick` (high every cycle) is legal and produces one step per cycle.
- `at_limit` is combinational from `count` and `up`. It must not be used to gate `tick` inside the block beyond the boundary logic above.
- `up` may change on any cycle. It takes effect on the next `tick` with no settling cycle.
- Simultaneous `load` and `tick`: the loaded value appears, and no step is applied on that edge.

## Test plan

- Reset and up count, `DIGITS`=4, `SATURATE`=0: release reset, apply 10 ticks → `count`=0x0010, `carry` stays 0. Continue to 10000 total ticks → `count`=0x0000 and a single `carry` pulse on the 10000th tick.
- Down with borrow: load 0x1000, one tick with `up`=0 → `count`=0x0999. Load 0x0000, tick with `up`=0 → `count`=0x9999, `carry` pulse.
- Saturate, `SATURATE`=1: load 0x9998, hold `tick` high for 3 cycles with `up`=1 → `count`=0x9999 after the first tick and stays there; `carry` pulses on ticks 2 and 3.
- Priority and clamping: `clear`, `load`(0x1234) and `tick` all high together → `count`=0x0000. Then `load`=0xF9A3 with `tick` high → `count`=0x9993, no step.
- Capture under counting: `tick` every cycle from 0, `capture` pulsed at the edge where `count`=0x0042 → `held`=0x0042 while `count` reads 0x0043. Pulse `reset_n` low mid-count → `count`, `held` and `carry` all 0 the next cycle.
- Width scaling: `DIGITS`=6, load 0x999999, one up tick → `count`=0x000000, `carry` pulse. `DIGITS`=1: 10 ticks → `count`=0x0, `carry` pulses once.
